// File: rtl/relay_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | relay_pkg : shared types and opcode constants for the sequencer |
// | Rev 1.0                                                         |
// +------------------------------------------------------------------+
package relay_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F0     = 4'd1,
    S_F1     = 4'd2,
    S_DEC    = 4'd3,
    S_E0     = 4'd4,
    S_E1     = 4'd5,
    S_G0     = 4'd6,
    S_G1     = 4'd7,
    S_G2     = 4'd8,
    S_G3     = 4'd9,
    S_G4     = 4'd10,
    S_G5     = 4'd11,
    S_HALTED = 4'd15
  } state_t;

  localparam logic [7:0] MOV8_MASK  = 8'hC0;
  localparam logic [7:0] MOV8_VAL   = 8'h00;
  localparam logic [7:0] SETAB_MASK = 8'hC0;
  localparam logic [7:0] SETAB_VAL  = 8'h40;
  localparam logic [7:0] ALU_MASK   = 8'hF0;
  localparam logic [7:0] ALU_VAL    = 8'h80;
  localparam logic [7:0] LOAD_MASK  = 8'hFC;
  localparam logic [7:0] LOAD_VAL   = 8'h90;
  localparam logic [7:0] STORE_MASK = 8'hFC;
  localparam logic [7:0] STORE_VAL  = 8'h98;
  localparam logic [7:0] INCXY_MASK = 8'hFF;
  localparam logic [7:0] INCXY_VAL  = 8'hB0;
  localparam logic [7:0] HALT_MASK  = 8'hFF;
  localparam logic [7:0] HALT_VAL   = 8'hAE;
  // Reserved GOTO bits [4] and [0] are deliberately outside the mask.
  localparam logic [7:0] GOTO_MASK  = 8'hC0;
  localparam logic [7:0] GOTO_VAL   = 8'hC0;

  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_B  = 3'd1;
  localparam logic [2:0] REG_C  = 3'd2;
  localparam logic [2:0] REG_D  = 3'd3;
  localparam logic [2:0] REG_M1 = 3'd4;
  localparam logic [2:0] REG_M2 = 3'd5;
  localparam logic [2:0] REG_X  = 3'd6;
  localparam logic [2:0] REG_Y  = 3'd7;

  localparam logic [2:0] ALU_IDLE = 3'b111;

  function automatic logic op_match(input logic [7:0] op,
                                    input logic [7:0] mask,
                                    input logic [7:0] val);
    return (op & mask) == val;
  endfunction

endpackage : relay_pkg
`default_nettype wire

// File: rtl/relay_reg_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | relay_reg_decode : 3-bit register code + enable -> 8-bit one-hot |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module relay_reg_decode (
  input  logic [2:0] i_code,
  input  logic       i_en,
  output logic [7:0] o_onehot
);

  assign o_onehot = i_en ? (8'd1 << i_code) : 8'h00;

endmodule : relay_reg_decode
`default_nettype wire

// File: rtl/relay_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | relay_sequencer : fetch/decode/execute control-strobe sequencer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module relay_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic [7:0] i_inst,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_sign,
  output logic [7:0] o_ld_reg,
  output logic [7:0] o_sel_reg,
  output logic       o_ld_xy,
  output logic       o_sel_xy,
  output logic       o_sel_m,
  output logic       o_ld_j1,
  output logic       o_ld_j2,
  output logic       o_sel_j,
  output logic       o_ld_inst,
  output logic       o_ld_pc,
  output logic       o_sel_pc,
  output logic       o_ld_inc,
  output logic       o_sel_inc,
  output logic       o_ld_cond,
  output logic [2:0] o_alu_func,
  output logic       o_alu_en,
  output logic       o_imm_en,
  output logic [7:0] o_imm,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_halt,
  output logic [3:0] o_fsm_state,
  output logic       o_instr_done
);

  import relay_pkg::*;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;

  logic [2:0] w_ld_code;
  logic       w_ld_en;
  logic [2:0] w_sel_code;
  logic       w_sel_en;

  logic w_is_mov, w_is_setab, w_is_alu, w_is_load, w_is_store;
  logic w_is_incxy, w_is_halt, w_is_goto;
  logic w_taken;

  assign w_is_mov   = op_match(r_ir, MOV8_MASK,  MOV8_VAL);
  assign w_is_setab = op_match(r_ir, SETAB_MASK, SETAB_VAL);
  assign w_is_alu   = op_match(r_ir, ALU_MASK,   ALU_VAL);
  assign w_is_load  = op_match(r_ir, LOAD_MASK,  LOAD_VAL);
  assign w_is_store = op_match(r_ir, STORE_MASK, STORE_VAL);
  assign w_is_incxy = op_match(r_ir, INCXY_MASK, INCXY_VAL);
  assign w_is_halt  = op_match(r_ir, HALT_MASK,  HALT_VAL);
  assign w_is_goto  = op_match(r_ir, GOTO_MASK,  GOTO_VAL);

  // GOTO condition bits: n=ir[3], c=ir[2], z=ir[1]; all clear means unconditional.
  assign w_taken = (r_ir[3:1] == 3'b000) | (r_ir[3] & i_sign) |
                   (r_ir[2] & i_carry) | (r_ir[1] & i_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_F0) begin
        r_ir <= i_inst;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_ld_code    = REG_A;
    w_ld_en      = 1'b0;
    w_sel_code   = REG_A;
    w_sel_en     = 1'b0;
    o_ld_xy      = 1'b0;
    o_sel_xy     = 1'b0;
    o_sel_m      = 1'b0;
    o_ld_j1      = 1'b0;
    o_ld_j2      = 1'b0;
    o_sel_j      = 1'b0;
    o_ld_inst    = 1'b0;
    o_ld_pc      = 1'b0;
    o_sel_pc     = 1'b0;
    o_ld_inc     = 1'b0;
    o_sel_inc    = 1'b0;
    o_ld_cond    = 1'b0;
    o_alu_func   = ALU_IDLE;
    o_alu_en     = 1'b0;
    o_imm_en     = 1'b0;
    o_imm        = 8'h00;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_instr_done = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_run) w_next = S_F0;
      end
      S_F0: begin
        o_sel_pc   = 1'b1;
        o_mem_read = 1'b1;
        o_ld_inst  = 1'b1;
        o_ld_inc   = 1'b1;
        w_next     = S_F1;
      end
      S_F1: begin
        o_sel_inc = 1'b1;
        o_ld_pc   = 1'b1;
        w_next    = S_DEC;
      end
      S_DEC: begin
        if (w_is_halt)      w_next = S_HALTED;
        else if (w_is_goto) w_next = S_G0;
        else                w_next = S_E0;
      end
      S_E0: begin
        if (w_is_mov) begin
          if (r_ir[5:3] != r_ir[2:0]) begin
            w_sel_code = r_ir[2:0];
            w_sel_en   = 1'b1;
            w_ld_code  = r_ir[5:3];
            w_ld_en    = 1'b1;
          end
        end else if (w_is_setab) begin
          o_imm_en  = 1'b1;
          o_imm     = {{3{r_ir[4]}}, r_ir[4:0]};
          w_ld_code = r_ir[5] ? REG_B : REG_A;
          w_ld_en   = 1'b1;
        end else if (w_is_alu) begin
          o_alu_en   = 1'b1;
          o_alu_func = r_ir[2:0];
          o_ld_cond  = 1'b1;
          w_ld_code  = r_ir[3] ? REG_D : REG_A;
          w_ld_en    = 1'b1;
        end else if (w_is_load) begin
          o_sel_m    = 1'b1;
          o_mem_read = 1'b1;
          w_ld_code  = {1'b0, r_ir[1:0]};
          w_ld_en    = 1'b1;
        end else if (w_is_store) begin
          o_sel_m     = 1'b1;
          o_mem_write = 1'b1;
          w_sel_code  = {1'b0, r_ir[1:0]};
          w_sel_en    = 1'b1;
        end else if (w_is_incxy) begin
          o_sel_xy = 1'b1;
          o_ld_inc = 1'b1;
        end

        if (w_is_incxy) begin
          w_next = S_E1;
        end else begin
          o_instr_done = 1'b1;
          w_next       = i_run ? S_F0 : S_IDLE;
        end
      end
      S_E1: begin
        o_sel_inc    = 1'b1;
        o_ld_xy      = 1'b1;
        o_instr_done = 1'b1;
        w_next       = i_run ? S_F0 : S_IDLE;
      end
      S_G0: begin
        o_sel_pc   = 1'b1;
        o_mem_read = 1'b1;
        o_ld_j1    = 1'b1;
        o_ld_inc   = 1'b1;
        w_next     = S_G1;
      end
      S_G1: begin
        o_sel_inc = 1'b1;
        o_ld_pc   = 1'b1;
        w_next    = S_G2;
      end
      S_G2: begin
        o_sel_pc   = 1'b1;
        o_mem_read = 1'b1;
        o_ld_j2    = 1'b1;
        o_ld_inc   = 1'b1;
        w_next     = S_G3;
      end
      S_G3: begin
        o_sel_inc = 1'b1;
        o_ld_pc   = 1'b1;
        w_next    = S_G4;
      end
      S_G4: begin
        // Call: PC (already past the operands) becomes the XY link.
        if (r_ir[5]) begin
          o_sel_pc = 1'b1;
          o_ld_xy  = 1'b1;
        end
        w_next = S_G5;
      end
      S_G5: begin
        if (w_taken) begin
          o_sel_j = 1'b1;
          o_ld_pc = 1'b1;
        end
        o_instr_done = 1'b1;
        w_next       = i_run ? S_F0 : S_IDLE;
      end
      S_HALTED: begin
        w_next = S_HALTED;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  relay_reg_decode u_ld_dec (
    .i_code   (w_ld_code),
    .i_en     (w_ld_en),
    .o_onehot (o_ld_reg)
  );

  relay_reg_decode u_sel_dec (
    .i_code   (w_sel_code),
    .i_en     (w_sel_en),
    .o_onehot (o_sel_reg)
  );

  assign o_halt      = (r_state == S_HALTED);
  assign o_fsm_state = r_state;

endmodule : relay_sequencer
`default_nettype wire

// File: tb/tb_relay_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_relay_sequencer : directed self-checking bench                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_relay_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] inst;
  logic       zero, carry, sign;
  logic [7:0] ld_reg, sel_reg, imm;
  logic       ld_xy, sel_xy, sel_m, ld_j1, ld_j2, sel_j;
  logic       ld_inst, ld_pc, sel_pc, ld_inc, sel_inc, ld_cond;
  logic [2:0] alu_func;
  logic       alu_en, imm_en, mem_read, mem_write, halt, instr_done;
  logic [3:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  localparam logic [17:0] B_LD_XY   = 18'd1 << 0;
  localparam logic [17:0] B_SEL_XY  = 18'd1 << 1;
  localparam logic [17:0] B_SEL_M   = 18'd1 << 2;
  localparam logic [17:0] B_LD_J1   = 18'd1 << 3;
  localparam logic [17:0] B_LD_J2   = 18'd1 << 4;
  localparam logic [17:0] B_SEL_J   = 18'd1 << 5;
  localparam logic [17:0] B_LD_INST = 18'd1 << 6;
  localparam logic [17:0] B_LD_PC   = 18'd1 << 7;
  localparam logic [17:0] B_SEL_PC  = 18'd1 << 8;
  localparam logic [17:0] B_LD_INC  = 18'd1 << 9;
  localparam logic [17:0] B_SEL_INC = 18'd1 << 10;
  localparam logic [17:0] B_LD_COND = 18'd1 << 11;
  localparam logic [17:0] B_ALU_EN  = 18'd1 << 12;
  localparam logic [17:0] B_IMM_EN  = 18'd1 << 13;
  localparam logic [17:0] B_MEM_RD  = 18'd1 << 14;
  localparam logic [17:0] B_MEM_WR  = 18'd1 << 15;
  localparam logic [17:0] B_HALT    = 18'd1 << 16;
  localparam logic [17:0] B_DONE    = 18'd1 << 17;

  localparam logic [17:0] FETCH_RD = B_SEL_PC | B_MEM_RD | B_LD_INC;
  localparam logic [17:0] PC_ADV   = B_SEL_INC | B_LD_PC;

  logic [17:0] strb;
  assign strb = {instr_done, halt, mem_write, mem_read, imm_en, alu_en, ld_cond,
                 sel_inc, ld_inc, sel_pc, ld_pc, ld_inst, sel_j, ld_j2, ld_j1,
                 sel_m, sel_xy, ld_xy};

  relay_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run        (run),
    .i_inst       (inst),
    .i_zero       (zero),
    .i_carry      (carry),
    .i_sign       (sign),
    .o_ld_reg     (ld_reg),
    .o_sel_reg    (sel_reg),
    .o_ld_xy      (ld_xy),
    .o_sel_xy     (sel_xy),
    .o_sel_m      (sel_m),
    .o_ld_j1      (ld_j1),
    .o_ld_j2      (ld_j2),
    .o_sel_j      (sel_j),
    .o_ld_inst    (ld_inst),
    .o_ld_pc      (ld_pc),
    .o_sel_pc     (sel_pc),
    .o_ld_inc     (ld_inc),
    .o_sel_inc    (sel_inc),
    .o_ld_cond    (ld_cond),
    .o_alu_func   (alu_func),
    .o_alu_en     (alu_en),
    .o_imm_en     (imm_en),
    .o_imm        (imm),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_halt       (halt),
    .o_fsm_state  (fsm_state),
    .o_instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data bus and address bus may each have at most one driver per cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("bus_data", 32'($countones({sel_reg, alu_en, imm_en, mem_read}) <= 1), 32'd1);
      check("bus_addr", 32'($countones({sel_pc, sel_inc, sel_xy, sel_m, sel_j}) <= 1), 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; inst = 8'h00;
    zero = 1'b0; carry = 1'b0; sign = 1'b0;
    repeat (2) tick();
    check("rst_state", fsm_state, 4'd0);
    check("rst_strb", strb, 18'd0);
    check("rst_alu", alu_func, 3'b111);
    check("rst_regs", {ld_reg, sel_reg, imm}, 24'd0);

    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle_hold", fsm_state, 4'd0);

    // MOV8 C -> B
    run = 1'b1; inst = 8'h0A;
    tick(); check("f0_state", fsm_state, 4'd1); check("f0_strb", strb, FETCH_RD | B_LD_INST);
    tick(); check("f1_state", fsm_state, 4'd2); check("f1_strb", strb, PC_ADV);
    tick(); check("dec_state", fsm_state, 4'd3); check("dec_strb", strb, 18'd0);
    tick(); check("mov_state", fsm_state, 4'd4);
    check("mov_sel", sel_reg, 8'h04); check("mov_ld", ld_reg, 8'h02);
    check("mov_strb", strb, B_DONE);
    tick(); check("mov_next_f0", fsm_state, 4'd1);

    // MOV8 A -> A is a NOP
    inst = 8'h00; repeat (3) tick();
    check("nop_regs", {ld_reg, sel_reg}, 16'h0000); check("nop_strb", strb, B_DONE);
    tick();

    // SETAB A = -1
    inst = 8'h5F; repeat (3) tick();
    check("setab_strb", strb, B_IMM_EN | B_DONE);
    check("setab_imm", imm, 8'hFF); check("setab_ld", ld_reg, 8'h01);
    tick();

    // SETAB B = +5
    inst = 8'h65; repeat (3) tick();
    check("setabB_imm", imm, 8'h05); check("setabB_ld", ld_reg, 8'h02);
    tick();

    // ALU func 1 into A, then drop run during E0
    inst = 8'h81; repeat (3) tick();
    check("alu_strb", strb, B_ALU_EN | B_LD_COND | B_DONE);
    check("alu_func", alu_func, 3'b001); check("alu_ld", ld_reg, 8'h01);
    run = 1'b0;
    tick(); check("stop_idle", fsm_state, 4'd0);
    tick(); check("stop_stay", fsm_state, 4'd0); check("stop_strb", strb, 18'd0);
    run = 1'b1;
    tick(); check("restart_f0", fsm_state, 4'd1);

    // GOTO on zero, not taken
    inst = 8'hC2; zero = 1'b0; repeat (3) tick();
    check("g0_state", fsm_state, 4'd6); check("g0_strb", strb, FETCH_RD | B_LD_J1);
    tick(); check("g1_strb", strb, PC_ADV);
    tick(); check("g2_state", fsm_state, 4'd8); check("g2_strb", strb, FETCH_RD | B_LD_J2);
    tick(); check("g3_strb", strb, PC_ADV);
    tick(); check("g4_nocall", strb, 18'd0);
    tick(); check("g5_state", fsm_state, 4'd11); check("g5_nottaken", strb, B_DONE);
    tick(); check("goto_next_f0", fsm_state, 4'd1);

    // GOTO on zero, taken
    inst = 8'hC2; zero = 1'b1; repeat (8) tick();
    check("g5_taken", strb, B_SEL_J | B_LD_PC | B_DONE);
    tick(); zero = 1'b0;

    // GOTO on carry|sign with only carry set, taken
    inst = 8'hCC; carry = 1'b1; repeat (8) tick();
    check("g5_carry", strb, B_SEL_J | B_LD_PC | B_DONE);
    tick(); carry = 1'b0;

    // Unconditional call
    inst = 8'hE0; repeat (7) tick();
    check("g4_call", strb, B_SEL_PC | B_LD_XY);
    tick(); check("g5_call", strb, B_SEL_J | B_LD_PC | B_DONE);
    tick();

    // INCXY
    inst = 8'hB0; repeat (3) tick();
    check("incxy_e0_state", fsm_state, 4'd4); check("incxy_e0", strb, B_SEL_XY | B_LD_INC);
    tick(); check("incxy_e1_state", fsm_state, 4'd5);
    check("incxy_e1", strb, B_SEL_INC | B_LD_XY | B_DONE);
    tick();

    // LOAD D, STORE C
    inst = 8'h93; repeat (3) tick();
    check("load_strb", strb, B_SEL_M | B_MEM_RD | B_DONE); check("load_ld", ld_reg, 8'h08);
    tick();
    inst = 8'h9A; repeat (3) tick();
    check("store_strb", strb, B_SEL_M | B_MEM_WR | B_DONE);
    check("store_regs", {ld_reg, sel_reg}, 16'h0004);
    tick();

    // Unassigned opcode behaves as a one-cycle NOP
    inst = 8'hA0; repeat (3) tick();
    check("undef_state", fsm_state, 4'd4); check("undef_strb", strb, B_DONE);
    tick();

    // Asynchronous reset in the middle of G2
    inst = 8'hC0; repeat (5) tick();
    check("pre_rst_g2", fsm_state, 4'd8);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", fsm_state, 4'd0); check("midrst_strb", strb, 18'd0);
    check("midrst_alu", alu_func, 3'b111);
    @(negedge clk) rst_n = 1'b1;
    tick(); check("post_rst_f0", fsm_state, 4'd1);

    // HALT
    inst = 8'hAE; tick(); tick();
    check("halt_dec", {fsm_state, halt}, {4'd3, 1'b0});
    tick(); check("halted_state", fsm_state, 4'd15); check("halted_strb", strb, B_HALT);
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halted_hold", {fsm_state, halt, mem_read}, {4'd15, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1;
    check("halt_clear", {fsm_state, halt}, {4'd0, 1'b0});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule : tb_relay_sequencer
`default_nettype wire
